// File: rtl/pc_gen_if.sv
// Fetch-PC / commit handshake bundle between pc_gen (master) and the core/IFU (slave).
interface pc_gen_if #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned CNT_WIDTH = 64
);
  logic [XLEN-1:0]      pc;
  logic                 pc_valid;
  logic                 pc_ready;
  logic                 commit_valid;
  logic [1:0]           pc_sel;
  logic [1:0]           adder_sel;
  logic [XLEN-1:0]      rs1_data;
  logic [XLEN-1:0]      imm;
  logic [XLEN-1:0]      mtvec;
  logic [XLEN-1:0]      mepc;
  logic                 misalign;
  logic [XLEN-1:0]      bad_target;
  logic [CNT_WIDTH-1:0] instret;

  modport master (
    output pc, pc_valid, misalign, bad_target, instret,
    input  pc_ready, commit_valid, pc_sel, adder_sel, rs1_data, imm, mtvec, mepc
  );

  modport slave (
    input  pc, pc_valid, misalign, bad_target, instret,
    output pc_ready, commit_valid, pc_sel, adder_sel, rs1_data, imm, mtvec, mepc
  );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator: offers pc to the IFU, then loads the next PC
// (adder, mtvec or mepc) when the fetched instruction commits.
module pc_gen #(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RST_VALUE   = 32'h8000_0000,
  parameter bit              ALIGN_CHECK = 1'b1,
  parameter int unsigned     CNT_WIDTH   = 64
) (
  input logic      clk,
  input logic      rst,
  pc_gen_if.master bus
);

  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [1:0]           state, state_nx;
  logic [XLEN-1:0]      pc_q, pc_nx;
  logic [XLEN-1:0]      bad_q, bad_nx;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_nx;
  logic                 valid_q, valid_nx;
  logic                 mis_q, mis_nx;
  logic [XLEN-1:0]      sum;
  logic [XLEN-1:0]      target;
  logic                 sum_misaligned;

  // Next-PC datapath; carry out of the adder is dropped so pc wraps.
  assign sum = (bus.adder_sel[1] ? bus.rs1_data : pc_q)
             + (bus.adder_sel[0] ? bus.imm      : XLEN'(4));

  // Only adder targets are alignment-checked; mtvec/mepc pass untouched.
  assign sum_misaligned = ALIGN_CHECK && !bus.pc_sel[0] && (sum[1:0] != 2'b00);

  always_comb begin
    target = sum;
    case (bus.pc_sel)
      2'b01:   target = bus.mtvec;
      2'b11:   target = bus.mepc;
      default: target = sum_misaligned ? bus.mtvec : sum;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= BOOT;
      pc_q    <= RST_VALUE;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      bad_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state   <= state_nx;
      pc_q    <= pc_nx;
      valid_q <= valid_nx;
      mis_q   <= mis_nx;
      bad_q   <= bad_nx;
      cnt_q   <= cnt_nx;
    end
  end

  // Next-state and registered-output values; misalign defaults low so it pulses.
  always_comb begin
    state_nx = state;
    pc_nx    = pc_q;
    valid_nx = valid_q;
    mis_nx   = 1'b0;
    bad_nx   = bad_q;
    cnt_nx   = cnt_q;
    case (state)
      BOOT: begin
        state_nx = FETCH;
        valid_nx = 1'b1;
      end
      FETCH: begin
        if (bus.pc_ready) begin
          state_nx = WAIT;
          valid_nx = 1'b0;
        end
      end
      WAIT: begin
        if (bus.commit_valid) begin
          state_nx = FETCH;
          valid_nx = 1'b1;
          pc_nx    = target;
          cnt_nx   = cnt_q + CNT_WIDTH'(1);
          if (sum_misaligned) begin
            mis_nx = 1'b1;
            bad_nx = sum;
          end
        end
      end
      default: begin
        state_nx = BOOT;
        valid_nx = 1'b0;
      end
    endcase
  end

  assign bus.pc         = pc_q;
  assign bus.pc_valid   = valid_q;
  assign bus.misalign   = mis_q;
  assign bus.bad_target = bad_q;
  assign bus.instret    = cnt_q;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: two instances (alignment check on/off) with shared stimulus,
// a cycle-level behavioural model, a directed vector table and random traffic.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_ready = 1'b0, commit_valid = 1'b0;
  logic [1:0]  pc_sel = 2'b00, adder_sel = 2'b00;
  logic [31:0] rs1_data = '0, imm = '0, mtvec = 32'h8000_0100, mepc = 32'h8000_0020;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  pc_gen_if bi ();
  pc_gen_if bn ();

  assign bi.pc_ready = pc_ready;     assign bn.pc_ready = pc_ready;
  assign bi.commit_valid = commit_valid; assign bn.commit_valid = commit_valid;
  assign bi.pc_sel = pc_sel;         assign bn.pc_sel = pc_sel;
  assign bi.adder_sel = adder_sel;   assign bn.adder_sel = adder_sel;
  assign bi.rs1_data = rs1_data;     assign bn.rs1_data = rs1_data;
  assign bi.imm = imm;               assign bn.imm = imm;
  assign bi.mtvec = mtvec;           assign bn.mtvec = mtvec;
  assign bi.mepc = mepc;             assign bn.mepc = mepc;

  pc_gen #(.ALIGN_CHECK(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(bi));
  pc_gen #(.ALIGN_CHECK(1'b0)) dut_n (.clk(clk), .rst(rst), .bus(bn));

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  bit          m_boot, m_offer, m_wait;
  logic [31:0] m_pc [2];
  logic [31:0] m_bad [2];
  bit          m_mis [2];
  logic [63:0] m_cnt;

  function automatic logic [31:0] sum_of(input logic [31:0] cur);
    logic [31:0] a, b;
    a = adder_sel[1] ? rs1_data : cur;
    b = adder_sel[0] ? imm : 32'd4;
    return a + b;
  endfunction

  function automatic bit mis_of(input logic [31:0] cur, input bit chk);
    return chk && (pc_sel == 2'b00 || pc_sel == 2'b10) && ((sum_of(cur) & 32'h3) != 32'h0);
  endfunction

  function automatic logic [31:0] pc_of(input logic [31:0] cur, input bit chk);
    if (pc_sel == 2'b01) return mtvec;
    if (pc_sel == 2'b11) return mepc;
    return mis_of(cur, chk) ? mtvec : sum_of(cur);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_boot <= 1'b1; m_offer <= 1'b0; m_wait <= 1'b0; m_cnt <= '0;
      for (int k = 0; k < 2; k++) begin
        m_pc[k] <= 32'h8000_0000; m_bad[k] <= '0; m_mis[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) m_mis[k] <= 1'b0;
      if (m_boot) begin
        m_boot <= 1'b0; m_offer <= 1'b1;
      end else if (m_offer) begin
        if (pc_ready) begin m_offer <= 1'b0; m_wait <= 1'b1; end
      end else if (m_wait && commit_valid) begin
        m_wait <= 1'b0; m_offer <= 1'b1; m_cnt <= m_cnt + 64'd1;
        for (int k = 0; k < 2; k++) begin
          m_pc[k] <= pc_of(m_pc[k], k == 0);
          if (mis_of(m_pc[k], k == 0)) begin
            m_mis[k] <= 1'b1; m_bad[k] <= sum_of(m_pc[k]);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("a.pc_valid", 64'(bi.pc_valid), 64'(m_offer));
      check("a.pc", 64'(bi.pc), 64'(m_pc[0]));
      check("a.misalign", 64'(bi.misalign), 64'(m_mis[0]));
      check("a.bad_target", 64'(bi.bad_target), 64'(m_bad[0]));
      check("a.instret", bi.instret, m_cnt);
      check("n.pc_valid", 64'(bn.pc_valid), 64'(m_offer));
      check("n.pc", 64'(bn.pc), 64'(m_pc[1]));
      check("n.misalign", 64'(bn.misalign), 64'(m_mis[1]));
      check("n.instret", bn.instret, m_cnt);
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [1:0]  psel;
    logic [1:0]  asel;
    logic [31:0] rs1;
    logic [31:0] imm;
    logic [31:0] tv;
    logic [31:0] ep;
    logic [31:0] pc_a;
    logic [31:0] pc_n;
    logic        mis_a;
    logic [31:0] bad_a;
  } vec_t;

  vec_t tbl [13];

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; pc_ready = 1'b0; commit_valid = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    while (bi.pc_valid !== 1'b1 && n < 8) begin cyc(); n++; end
    if (bi.pc_valid !== 1'b1) check({nm, ".timeout"}, 64'(bi.pc_valid), 64'd1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string nm;
    nm = $sformatf("vec%0d", idx);
    pc_ready = 1'b0; commit_valid = 1'b0;
    wait_valid(nm);
    pc_ready = 1'b1; cyc(); pc_ready = 1'b0;
    pc_sel = v.psel; adder_sel = v.asel; rs1_data = v.rs1; imm = v.imm;
    mtvec = v.tv; mepc = v.ep; commit_valid = 1'b1;
    cyc();
    commit_valid = 1'b0;
    rs1_data = $urandom; imm = $urandom; mtvec = $urandom; mepc = $urandom;
    check({nm, ".pc_a"}, 64'(bi.pc), 64'(v.pc_a));
    check({nm, ".pc_n"}, 64'(bn.pc), 64'(v.pc_n));
    check({nm, ".mis_a"}, 64'(bi.misalign), 64'(v.mis_a));
    check({nm, ".mis_n"}, 64'(bn.misalign), 64'd0);
    check({nm, ".bad_a"}, 64'(bi.bad_target), 64'(v.bad_a));
    check({nm, ".bad_n"}, 64'(bn.bad_target), 64'd0);
    check({nm, ".instret"}, bi.instret, 64'(idx + 1));
    check({nm, ".valid"}, 64'(bi.pc_valid), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (compared %0d)", n_cmp);
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{2'b00, 2'b00, 32'h0,        32'h0,        32'h8000_0100, 32'h8000_0020, 32'h8000_0004, 32'h8000_0004, 1'b0, 32'h0};
    tbl[1]  = '{2'b00, 2'b00, 32'h0,        32'h0,        32'h8000_0100, 32'h8000_0020, 32'h8000_0008, 32'h8000_0008, 1'b0, 32'h0};
    tbl[2]  = '{2'b00, 2'b11, 32'h8000_1000, 32'h10,       32'h8000_0100, 32'h8000_0020, 32'h8000_1010, 32'h8000_1010, 1'b0, 32'h0};
    tbl[3]  = '{2'b00, 2'b11, 32'h8000_0010, 32'h0,        32'h8000_0100, 32'h8000_0020, 32'h8000_0010, 32'h8000_0010, 1'b0, 32'h0};
    tbl[4]  = '{2'b00, 2'b01, 32'h0,        32'hFFFF_FFF8, 32'h8000_0100, 32'h8000_0020, 32'h8000_0008, 32'h8000_0008, 1'b0, 32'h0};
    tbl[5]  = '{2'b01, 2'b00, 32'h0,        32'h0,        32'h8000_0100, 32'h8000_0020, 32'h8000_0100, 32'h8000_0100, 1'b0, 32'h0};
    tbl[6]  = '{2'b11, 2'b00, 32'h0,        32'h0,        32'h8000_0100, 32'h8000_0020, 32'h8000_0020, 32'h8000_0020, 1'b0, 32'h0};
    tbl[7]  = '{2'b10, 2'b01, 32'h0,        32'h20,       32'h8000_0100, 32'h8000_0020, 32'h8000_0040, 32'h8000_0040, 1'b0, 32'h0};
    tbl[8]  = '{2'b00, 2'b11, 32'h8000_0002, 32'h0,        32'h8000_0100, 32'h8000_0020, 32'h8000_0100, 32'h8000_0002, 1'b1, 32'h8000_0002};
    tbl[9]  = '{2'b00, 2'b11, 32'hFFFF_FFFC, 32'h0,        32'h8000_0100, 32'h8000_0020, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 32'h8000_0002};
    tbl[10] = '{2'b00, 2'b00, 32'h0,        32'h0,        32'h8000_0100, 32'h8000_0020, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h8000_0002};
    tbl[11] = '{2'b01, 2'b00, 32'h0,        32'h0,        32'h8000_0102, 32'h8000_0020, 32'h8000_0102, 32'h8000_0102, 1'b0, 32'h8000_0002};
    tbl[12] = '{2'b10, 2'b01, 32'h0,        32'h2,        32'h8000_0100, 32'h8000_0020, 32'h8000_0104, 32'h8000_0104, 1'b0, 32'h8000_0002};

    // reset values
    cyc();
    chk_en = 1'b1;
    check("rst.pc", 64'(bi.pc), 64'h8000_0000);
    check("rst.valid", 64'(bi.pc_valid), 64'd0);
    check("rst.instret", bi.instret, 64'd0);

    // full-speed loop: one new PC every 2 cycles
    pc_ready = 1'b1; commit_valid = 1'b1; pc_sel = 2'b00; adder_sel = 2'b00;
    cyc();
    rst = 1'b0;
    check("boot.valid", 64'(bi.pc_valid), 64'd0);
    cyc();
    check("fs0.valid", 64'(bi.pc_valid), 64'd1);
    check("fs0.pc", 64'(bi.pc), 64'h8000_0000);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      check("fs.wait_valid", 64'(bi.pc_valid), 64'd0);
      cyc();
      check("fs.pc", 64'(bi.pc), 64'(32'h8000_0000 + 32'(4 * i)));
      check("fs.instret", bi.instret, 64'(i));
    end

    // stall in FETCH with commit pulses ignored
    do_reset();
    cyc();
    for (int i = 0; i < 5; i++) begin
      commit_valid = i[0];
      cyc();
      check("stall.valid", 64'(bi.pc_valid), 64'd1);
      check("stall.pc", 64'(bi.pc), 64'h8000_0000);
      check("stall.instret", bi.instret, 64'd0);
    end
    commit_valid = 1'b0;

    for (int i = 0; i < 13; i++) run_vec(tbl[i], i);

    // reset in WAIT with a commit pending
    wait_valid("midrst");
    pc_ready = 1'b1; cyc(); pc_ready = 1'b0;
    commit_valid = 1'b1; rst = 1'b1; pc_sel = 2'b00; adder_sel = 2'b00;
    cyc();
    commit_valid = 1'b0; rst = 1'b0;
    check("midrst.pc", 64'(bi.pc), 64'h8000_0000);
    check("midrst.instret", bi.instret, 64'd0);
    check("midrst.valid", 64'(bi.pc_valid), 64'd0);
    cyc();
    check("midrst.first_valid", 64'(bi.pc_valid), 64'd1);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      pc_ready     = 1'($urandom_range(0, 1));
      commit_valid = 1'($urandom_range(0, 1));
      pc_sel       = 2'($urandom_range(0, 3));
      adder_sel    = 2'($urandom_range(0, 3));
      rs1_data     = $urandom & 32'hFFFF_FFFC;
      imm          = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 5) == 0) rs1_data[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 5) == 0) imm[1:0] = 2'($urandom_range(1, 3));
      mtvec = $urandom;
      mepc  = $urandom;
      rst   = ($urandom_range(0, 99) == 0);
      cyc();
    end
    rst = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised program-counter generator for the multi-cycle NPC core. It holds the architectural PC and presents it to the IFU over a valid/ready handshake. It waits for the committing instruction's next-PC decision, then computes the next PC from:
- a configurable adder (pc/rs1 + 4/imm);
- a trap vector (mtvec);
- an mret return address (mepc).
Additional features: misaligned-target detection with automatic redirect to mtvec, and a retired-instruction counter.

Parameters:
XLEN, 32, datapath width of PC, rs1, imm, mtvec, mepc.
RST_VALUE, 32'h80000000, PC value loaded on reset.
ALIGN_CHECK, 1, 1 = detect next PC with [1:0]!=0 and redirect to mtvec; 0 = no check.
CNT_WIDTH, 64, width of the retired-instruction counter.

Ports:
clk  input  1  clock.
rst  input  1  reset (synchronous, active-high).
pc  output  XLEN  current fetch PC.
pc_valid  output  1  pc is offered to IFU.
pc_ready  input  1  IFU accepts pc this cycle.
commit_valid  input  1  instruction fetched at pc has completed; next-PC controls valid.
pc_sel  input  2  00 adder, 01 mtvec, 11 mepc, 10 adder.
adder_sel  input  2  [1]: A = rs1 (1) / pc (0); [0]: B = imm (1) / 4 (0).
rs1_data  input  XLEN  register operand for jalr.
imm  input  XLEN  immediate.
mtvec  input  XLEN  trap vector.
mepc  input  XLEN  trap return address.
misalign  output  1  one-cycle pulse: computed target misaligned, redirected to mtvec.
bad_target  output  XLEN  last misaligned target, held until next misalign.
instret  output  CNT_WIDTH  count of commits accepted.

Behaviour:
- Reset values:
  - pc = RST_VALUE; pc_valid = 0; misalign = 0; bad_target = 0; instret = 0.
  - State = BOOT.
  - rst dominates every other input in the same cycle.
- BOOT:
  - One cycle with pc_valid = 0, then go to FETCH.
  - First valid PC appears in cycle 2 after rst deasserts.
- FETCH:
  - pc_valid = 1; pc is held stable while pc_ready = 0.
  - On pc_valid & pc_ready, go to WAIT next cycle; pc_valid = 0 in WAIT.
  - commit_valid in FETCH is ignored: no PC change, no count.
- WAIT:
  - pc_valid = 0; pc is held.
  - On commit_valid, compute target:
    - sum = A + B, mod 2^XLEN, carry discarded.
    - target = pc_sel==01 ? mtvec : pc_sel==11 ? mepc : sum.
  - Next cycle: pc = target, instret += 1 (wraps at 2^CNT_WIDTH), state = FETCH.
  - pc_ready in WAIT is ignored.
- Misalign:
  - Applies only if ALIGN_CHECK=1, pc_sel is 00 or 10, and sum[1:0] != 0.
  - Result: pc = mtvec instead of sum; misalign = 1 for exactly that cycle; bad_target = sum; instret still increments.
  - mtvec/mepc targets are never checked.
- Operand sampling:
  - All next-PC inputs are sampled only in the commit_valid cycle in WAIT; their values at other times are don't-care.
- Latency:
  - Handshake-to-WAIT: 1 cycle.
  - Commit-to-new-pc_valid: 1 cycle.
  - Minimum per-instruction loop: 2 cycles, with pc_ready and commit_valid held high.
- Reset mid-operation:
  - Any state returns to BOOT; any pending commit is discarded; instret = 0.
- Wrap-around:
  - pc = 32'hFFFFFFFC with adder pc+4 gives pc = 0 and no misalign.

Test Plan:
- Reset then hold pc_ready=1, commit_valid=1, pc_sel=00, adder_sel=00 -> pc_valid low 1 cycle, then pc sequence 80000000, 80000004, 80000008, one new PC every 2 cycles; instret = 1, 2, 3.
- Stall: pc_ready=0 for 5 cycles in FETCH -> pc_valid=1 and pc=80000000 held, instret unchanged; commit_valid pulses during the stall are ignored.
- Jump/jalr: adder_sel=11, rs1=80001000, imm=10 -> pc=80001010. adder_sel=01, imm=FFFFFFF8 from pc 80000010 -> pc=80000008.
- Trap/mret: pc_sel=01, mtvec=80000100 -> pc=80000100. pc_sel=11, mepc=80000020 -> pc=80000020. pc_sel=10 -> adder result.
- Misalign: adder_sel=11, rs1=80000002, imm=0, mtvec=80000100 -> pc=80000100, misalign one-cycle pulse, bad_target=80000002. Same stimulus with ALIGN_CHECK=0 -> pc=80000002, no pulse.
- rst asserted in WAIT with commit_valid=1 -> pc=80000000, instret=0, state BOOT. Wrap case: pc FFFFFFFC + 4 -> pc=00000000.
